// File: rtl/jtframe_romload_arb.sv
// Packs ROM-loader bytes into 16-bit words, buffers them in a small FIFO
// and shares the single SDRAM port between download writes and game reads.
module jtframe_romload_arb #(
    parameter int AW         = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    input  logic          downloading,
    input  logic          game_req,
    input  logic [AW-2:0] game_addr,
    output logic          game_ack,
    output logic [15:0]   game_data,
    output logic          game_rdy,
    output logic          sdram_req,
    output logic          sdram_we,
    output logic [AW-2:0] sdram_addr,
    output logic [15:0]   sdram_din,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [15:0]   sdram_dout,
    output logic          dwn_busy,
    output logic          dwn_done,
    output logic          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ROOM2_C = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, WR, RD, RDWAIT} state_t;

    state_t        state_q;
    logic          req_q, we_q, gack_q, grdy_q;
    logic [AW-2:0] addr_q;
    logic [15:0]   din_q, gdata_q;

    logic          pend_v_q, pend_v_d;
    logic [AW-2:0] pend_a_q, pend_a_d;
    logic [15:0]   pend_w_q, pend_w_d;
    logic [1:0]    pend_m_q, pend_m_d;

    logic [AW-2:0] fifo_a_q [FIFO_DEPTH];
    logic [15:0]   fifo_w_q [FIFO_DEPTH];
    logic [PW-1:0] rp_q, wp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, busy_q, done_q;

    logic          push, pop, push_ok, drop, odd, fifo_empty;
    logic [AW-2:0] push_a, byte_wa;
    logic [15:0]   push_w, base_w, merge_w, fresh_w;
    logic [1:0]    byte_m, merge_m;

    assign odd     = ioctl_addr[0];
    assign byte_wa = ioctl_addr[AW-1:1];
    assign byte_m  = odd ? 2'b10 : 2'b01;
    assign base_w  = pend_v_q ? pend_w_q : 16'hFFFF;
    assign merge_w = odd ? {ioctl_data, base_w[7:0]} : {base_w[15:8], ioctl_data};
    assign merge_m = (pend_v_q ? pend_m_q : 2'b00) | byte_m;
    assign fresh_w = odd ? {ioctl_data, 8'hFF} : {8'hFF, ioctl_data};

    // Missing halves stay 0xFF so a flush needs no extra padding logic
    always_comb begin
        pend_v_d = pend_v_q;
        pend_a_d = pend_a_q;
        pend_w_d = pend_w_q;
        pend_m_d = pend_m_q;
        push     = 1'b0;
        push_a   = pend_a_q;
        push_w   = pend_w_q;
        drop     = 1'b0;
        if (ioctl_wr) begin
            if (pend_v_q && byte_wa != pend_a_q) begin
                push = 1'b1;
                if (cnt_q <= ROOM2_C) begin
                    pend_a_d = byte_wa;
                    pend_w_d = fresh_w;
                    pend_m_d = byte_m;
                end else begin
                    pend_v_d = 1'b0;
                    pend_m_d = 2'b00;
                    drop     = 1'b1;
                end
            end else if (merge_m == 2'b11) begin
                push     = 1'b1;
                push_a   = byte_wa;
                push_w   = merge_w;
                pend_v_d = 1'b0;
                pend_m_d = 2'b00;
            end else begin
                pend_v_d = 1'b1;
                pend_a_d = byte_wa;
                pend_w_d = merge_w;
                pend_m_d = merge_m;
            end
        end else if (!downloading && pend_v_q) begin
            push     = 1'b1;
            pend_v_d = 1'b0;
            pend_m_d = 2'b00;
        end
    end

    assign fifo_empty = (cnt_q == '0);
    assign pop        = (state_q == WR) && sdram_ack;
    assign push_ok    = push && (cnt_q != FULL_C || pop);

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop) cnt_d = cnt_q + CW'(1);
        if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_rom) begin
        if (!rst_n) begin
            pend_v_q <= 1'b0;
            pend_a_q <= '0;
            pend_w_q <= 16'hFFFF;
            pend_m_q <= 2'b00;
            rp_q     <= '0;
            wp_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_a_q <= pend_a_d;
            pend_w_q <= pend_w_d;
            pend_m_q <= pend_m_d;
            if (push_ok) wp_q <= wp_q + PW'(1);
            if (pop) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_d;
            if ((push && !push_ok) || drop) ovf_q <= 1'b1;
            busy_q <= dwn_busy;
            done_q <= busy_q && !dwn_busy;
        end
    end

    always_ff @(posedge clk_rom) begin
        if (push_ok) begin
            fifo_a_q[wp_q] <= push_a;
            fifo_w_q[wp_q] <= push_w;
        end
    end

    // Writes are checked first so downloads always win the port
    always_ff @(posedge clk_rom) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            gack_q  <= 1'b0;
            grdy_q  <= 1'b0;
            gdata_q <= '0;
        end else begin
            gack_q <= 1'b0;
            grdy_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= WR;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= fifo_a_q[rp_q];
                        din_q   <= fifo_w_q[rp_q];
                    end else if (game_req && !dwn_busy) begin
                        state_q <= RD;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= game_addr;
                    end
                end
                WR: if (sdram_ack) begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
                RD: if (sdram_ack) begin
                    req_q   <= 1'b0;
                    gack_q  <= 1'b1;
                    state_q <= RDWAIT;
                end
                RDWAIT: if (sdram_rdy) begin
                    gdata_q <= sdram_dout;
                    grdy_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dwn_busy   = downloading || pend_v_q || !fifo_empty || (state_q == WR);
    assign dwn_done   = done_q;
    assign overflow   = ovf_q;
    assign sdram_req  = req_q;
    assign sdram_we   = we_q;
    assign sdram_addr = addr_q;
    assign sdram_din  = din_q;
    assign game_ack   = gack_q;
    assign game_rdy   = grdy_q;
    assign game_data  = gdata_q;
endmodule

// File: tb/tb_jtframe_romload_arb.sv
// Bench for jtframe_romload_arb: directed and random download/read
// scenarios against a word-level model and an SDRAM responder.
module tb_jtframe_romload_arb;
    localparam int AW = 22;

    logic          clk, rst_n;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_data;
    logic          ioctl_wr, downloading, game_req;
    logic [AW-2:0] game_addr;
    logic          game_ack, game_rdy;
    logic [15:0]   game_data;
    logic          sdram_req, sdram_we;
    logic [AW-2:0] sdram_addr;
    logic [15:0]   sdram_din;
    logic          sdram_ack, sdram_rdy;
    logic [15:0]   sdram_dout;
    logic          dwn_busy, dwn_done, overflow;

    jtframe_romload_arb #(.AW(AW), .FIFO_DEPTH(4)) dut (
        .clk_rom(clk), .rst_n(rst_n),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .downloading(downloading),
        .game_req(game_req), .game_addr(game_addr),
        .game_ack(game_ack), .game_data(game_data), .game_rdy(game_rdy),
        .sdram_req(sdram_req), .sdram_we(sdram_we),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din),
        .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
        .sdram_dout(sdram_dout),
        .dwn_busy(dwn_busy), .dwn_done(dwn_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -1, gack_cnt = 0, grdy_cnt = 0;
    int sack_cyc = -1, srdy_cyc = -1, rdreq_cyc = -1;
    int rdy_cd = 0, rd_lat = 2, ack_rand = 1;
    logic ack_en = 1'b1, force_ack = 1'b0, force_rdy = 1'b0;
    logic [15:0] rd_val = 16'h0;
    logic [36:0] wr_q [$];
    logic [36:0] exp_q [$];
    logic [15:0] sdram_mem [int];
    logic [15:0] model_mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dwn_done) begin done_cnt++; done_cyc = cyc; end
        if (game_ack) gack_cnt++;
        if (game_rdy) grdy_cnt++;
    end

    // SDRAM responder, acting 2 time units after each rising edge
    always begin
        @(posedge clk); #2;
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        if (rdy_cd > 0) begin
            rdy_cd--;
            if (rdy_cd == 0) begin
                sdram_rdy = 1'b1; sdram_dout = rd_val; srdy_cyc = cyc;
            end
        end
        if (force_rdy) sdram_rdy = 1'b1;
        if (sdram_req && !sdram_we && rdreq_cyc < 0) rdreq_cyc = cyc;
        if (force_ack) sdram_ack = 1'b1;
        else if (sdram_req && ack_en && $urandom_range(0, ack_rand) == 0) begin
            sdram_ack = 1'b1;
            sack_cyc = cyc;
            if (sdram_we) begin
                wr_q.push_back({sdram_addr, sdram_din});
                sdram_mem[int'(sdram_addr)] = sdram_din;
            end else begin
                rd_val = sdram_mem.exists(int'(sdram_addr)) ? sdram_mem[int'(sdram_addr)] : 16'h0;
                rdy_cd = rd_lat;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input int a, input logic [7:0] d, input int gap);
        ioctl_addr = 22'(a); ioctl_data = d; ioctl_wr = 1'b1;
        tick;
        ioctl_wr = 1'b0;
        repeat (gap) tick;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((dwn_busy || sdram_req) && n < 3000) begin tick; n++; end
        chk({tag, "_drain"}, 64'(n < 3000), 64'(1));
        repeat (3) tick;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
    endtask

    task automatic finish_read(input logic [15:0] exp, input string tag);
        int n = 0;
        while (!game_ack && n < 200) begin tick; n++; end
        chk({tag, "_ack"}, 64'(game_ack), 64'(1));
        chk({tag, "_acklat"}, 64'(cyc - sack_cyc), 64'(1));
        game_req = 1'b0;
        n = 0;
        while (!game_rdy && n < 200) begin tick; n++; end
        chk({tag, "_rdy"}, 64'(game_rdy), 64'(1));
        chk({tag, "_rdylat"}, 64'(cyc - srdy_cyc), 64'(1));
        chk({tag, "_data"}, 64'(game_data), 64'(exp));
        repeat (2) tick;
    endtask

    initial begin
        int d0, g0, prev, wa, kind, k;
        logic [7:0] lo, hi;
        logic [20:0] ra;

        rst_n = 1'b0; ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0;
        downloading = 1'b0; game_req = 1'b0; game_addr = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
        sdram_mem[32'h1234] = 16'hBEEF;
        repeat (3) tick;
        chk("rst_req", 64'(sdram_req), 64'(0));
        chk("rst_we", 64'(sdram_we), 64'(0));
        chk("rst_addr", 64'(sdram_addr), 64'(0));
        chk("rst_din", 64'(sdram_din), 64'(0));
        chk("rst_gdata", 64'(game_data), 64'(0));
        chk("rst_gack", 64'(game_ack), 64'(0));
        chk("rst_grdy", 64'(game_rdy), 64'(0));
        chk("rst_busy", 64'(dwn_busy), 64'(0));
        chk("rst_done", 64'(dwn_done), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        tick;

        // sequential download with request latency
        d0 = done_cnt; wr_q.delete(); exp_q.delete();
        downloading = 1'b1; tick;
        send_byte(0, 8'h11, 3);
        send_byte(1, 8'h22, 0);
        chk("seq_lat1_req", 64'(sdram_req), 64'(0));
        tick;
        chk("seq_lat2_req", 64'(sdram_req), 64'(1));
        chk("seq_lat2_we", 64'(sdram_we), 64'(1));
        chk("seq_lat2_addr", 64'(sdram_addr), 64'(0));
        chk("seq_lat2_din", 64'(sdram_din), 64'(16'h2211));
        repeat (3) tick;
        send_byte(2, 8'h33, 3);
        send_byte(3, 8'h44, 3);
        downloading = 1'b0;
        wait_drain("seq");
        exp_q = '{{21'd0, 16'h2211}, {21'd1, 16'h4433}};
        check_writes("seq");
        chk("seq_done", 64'(done_cnt - d0), 64'(1));
        chk("seq_ovf", 64'(overflow), 64'(0));

        // odd tail padded on downloading fall
        d0 = done_cnt; wr_q.delete();
        downloading = 1'b1; tick;
        send_byte(0, 8'h11, 3); send_byte(1, 8'h22, 3);
        send_byte(2, 8'h33, 3); send_byte(3, 8'h44, 3);
        send_byte(4, 8'h55, 3);
        downloading = 1'b0;
        wait_drain("tail");
        exp_q = '{{21'd0, 16'h2211}, {21'd1, 16'h4433}, {21'd2, 16'hFF55}};
        check_writes("tail");
        chk("tail_done", 64'(done_cnt - d0), 64'(1));

        // non-sequential bytes flush the pending half
        wr_q.delete();
        downloading = 1'b1; tick;
        send_byte(6, 8'hAA, 4);
        send_byte(20, 8'h77, 4);
        downloading = 1'b0;
        wait_drain("nseq");
        exp_q = '{{21'd3, 16'hFFAA}, {21'd10, 16'hFF77}};
        check_writes("nseq");

        // overflow with stalled SDRAM
        wr_q.delete();
        ack_en = 1'b0;
        downloading = 1'b1; tick;
        for (int i = 0; i < 10; i++) send_byte(i, 8'(i + 1), 3);
        chk("ovf_set", 64'(overflow), 64'(1));
        downloading = 1'b0;
        ack_en = 1'b1;
        wait_drain("ovf");
        exp_q = '{{21'd0, 16'h0201}, {21'd1, 16'h0403},
                  {21'd2, 16'h0605}, {21'd3, 16'h0807}};
        check_writes("ovf");
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // reset while a write is pending with two words queued
        wr_q.delete();
        ack_en = 1'b0;
        downloading = 1'b1; tick;
        for (int i = 0; i < 4; i++) send_byte(i, 8'($urandom), 3);
        repeat (3) tick;
        chk("rstw_pre_req", 64'(sdram_req), 64'(1));
        downloading = 1'b0; rst_n = 1'b0;
        tick;
        chk("rstw_req", 64'(sdram_req), 64'(0));
        chk("rstw_busy", 64'(dwn_busy), 64'(0));
        chk("rstw_ovf", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        d0 = done_cnt;
        ack_en = 1'b1; force_ack = 1'b1;
        tick;
        force_ack = 1'b0;
        repeat (6) tick;
        chk("rstw_req2", 64'(sdram_req), 64'(0));
        chk("rstw_nwr", 64'(wr_q.size()), 64'(0));
        chk("rstw_busy2", 64'(dwn_busy), 64'(0));
        chk("rstw_nodone", 64'(done_cnt - d0), 64'(0));

        // directed read
        ack_en = 1'b0; ack_rand = 0; rd_lat = 2;
        game_addr = 21'h1234; game_req = 1'b1;
        tick;
        chk("rd_req", 64'(sdram_req), 64'(1));
        chk("rd_we", 64'(sdram_we), 64'(0));
        chk("rd_addr", 64'(sdram_addr), 64'(21'h1234));
        ack_en = 1'b1;
        finish_read(16'hBEEF, "rd");

        // stray strobes in IDLE are ignored
        g0 = grdy_cnt; d0 = gack_cnt;
        force_rdy = 1'b1; force_ack = 1'b1;
        tick;
        force_rdy = 1'b0; force_ack = 1'b0;
        repeat (3) tick;
        chk("stray_grdy", 64'(grdy_cnt - g0), 64'(0));
        chk("stray_gack", 64'(gack_cnt - d0), 64'(0));
        chk("stray_req", 64'(sdram_req), 64'(0));

        // read held off while downloading
        ack_rand = 1; rdreq_cyc = -1;
        downloading = 1'b1; tick;
        game_addr = 21'd50; game_req = 1'b1;
        repeat (5) tick;
        chk("rdbusy_hold", 64'(sdram_req), 64'(0));
        send_byte(100, 8'hC3, 3);
        send_byte(101, 8'h3C, 3);
        downloading = 1'b0;
        finish_read(16'h3CC3, "rdbusy");
        chk("rdbusy_order", 64'(rdreq_cyc >= done_cyc && done_cyc >= 0), 64'(1));

        // random download against the word-level model
        wr_q.delete(); exp_q.delete();
        ack_rand = 2; prev = -1;
        d0 = done_cnt;
        downloading = 1'b1; tick;
        for (int i = 0; i < 24; i++) begin
            do wa = int'($urandom_range(0, 63)); while (wa == prev);
            prev = wa;
            kind = int'($urandom_range(0, 2));
            lo = 8'($urandom); hi = 8'($urandom);
            if (kind == 0) begin
                send_byte(2 * wa, lo, int'($urandom_range(5, 7)));
                send_byte(2 * wa + 1, hi, int'($urandom_range(5, 7)));
                exp_q.push_back({21'(wa), hi, lo});
            end else if (kind == 1) begin
                send_byte(2 * wa, lo, int'($urandom_range(5, 7)));
                exp_q.push_back({21'(wa), 8'hFF, lo});
            end else begin
                send_byte(2 * wa + 1, hi, int'($urandom_range(5, 7)));
                exp_q.push_back({21'(wa), hi, 8'hFF});
            end
        end
        downloading = 1'b0;
        wait_drain("rnd");
        check_writes("rnd");
        chk("rnd_done", 64'(done_cnt - d0), 64'(1));
        chk("rnd_ovf", 64'(overflow), 64'(0));
        foreach (exp_q[i]) model_mem[int'(exp_q[i][36:16])] = exp_q[i][15:0];

        for (int i = 0; i < 6; i++) begin
            k = int'($urandom_range(0, exp_q.size() - 1));
            ra = exp_q[k][36:16];
            rd_lat = int'($urandom_range(1, 3));
            game_addr = ra; game_req = 1'b1;
            finish_read(model_mem[int'(ra)], $sformatf("rnd_rd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
